elastic_pipe: RTL and testbench

Parametrised, back-pressured register pipeline. It carries a WIDTH-bit data word through STAGES register stages with a valid/ready handshake, a synchronous flush and an occupancy count. It replaces fixed two-register data delay chains wherever a producer and consumer need a fixed-latency, stallable path.

---
 rtl/elastic_pipe_pkg.sv | 8 +
 rtl/elastic_pipe_stage.sv | 36 +++
 rtl/elastic_pipe.sv | 86 ++++++++
 tb/tb_elastic_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/elastic_pipe_pkg.sv
// Shared helpers for the elastic pipeline: occupancy arithmetic.
package elastic_pipe_pkg;

    function automatic int occ_step(input int occ, input logic push, input logic pop);
        return occ + (push ? 1 : 0) - (pop ? 1 : 0);
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One valid/data register slot of the elastic pipeline with its local ready term.
module elastic_pipe_stage #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             up_ready
);

    // An empty slot can always take a word; a full one only if it drains downstream.
    assign up_ready = !valid || dn_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= RESET_DATA;
        end else if (flush) begin
            valid <= 1'b0;
            data  <= RESET_DATA;
        end else if (up_ready) begin
            valid <= up_valid;
            // Data only moves with a real word so bubbles cause no toggling.
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipe.sv
// Stallable fixed-latency register pipeline with flush and an occupancy count.
module elastic_pipe
    import elastic_pipe_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               STAGES     = 2,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(STAGES+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    // Handshake: a word moves across a port on an edge where valid and ready are
    // both high; flush drops both port readies/valids for that cycle.
    logic push;
    logic pop;

    genvar i;
    generate
        for (i = 0; i < STAGES; i++) begin : stg
            logic             up_valid;
            logic [WIDTH-1:0] up_data;
            logic             dn_ready;
            logic             valid;
            logic [WIDTH-1:0] data;
            logic             ready;

            if (i == 0) begin : g_head
                assign up_valid = in_valid;
                assign up_data  = in_data;
            end else begin : g_link
                assign up_valid = stg[i-1].valid;
                assign up_data  = stg[i-1].data;
            end

            if (i == STAGES - 1) begin : g_tail
                assign dn_ready = out_ready;
            end else begin : g_mid
                assign dn_ready = stg[i+1].ready;
            end

            elastic_pipe_stage #(
                .WIDTH      (WIDTH),
                .RESET_DATA (RESET_DATA)
            ) u_stage (
                .clk      (clk),
                .reset_n  (reset_n),
                .flush    (flush),
                .up_valid (up_valid),
                .up_data  (up_data),
                .dn_ready (dn_ready),
                .valid    (valid),
                .data     (data),
                .up_ready (ready)
            );
        end
    endgenerate

    assign in_ready  = stg[0].ready && !flush;
    assign out_valid = stg[STAGES-1].valid && !flush;
    assign out_data  = stg[STAGES-1].data;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= OCC_W'(occ_step(int'(occupancy), push, pop));
        end
    end

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe: 3-stage 8-bit instance with a queue model, plus a 1-stage 32-bit instance.
module tb_elastic_pipe;

    localparam int               STG_A = 3;
    localparam logic [31:0]      RST_B = 32'hA5A5_0000;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        int          e_occ;
    } vec_t;

    logic clk;
    logic reset_n;

    logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
    logic [1:0] a_occ;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [0:0]  b_occ;

    int checks   = 0;
    int failures = 0;

    // Reference model: words in flight in order, with the edge each was accepted on.
    logic [7:0] exp_q[$];
    int         exp_t[$];
    int         edge_n   = 0;
    logic [7:0] last_out = 8'h00;

    vec_t tab_a[14];
    vec_t tab_b[8];

    elastic_pipe #(.WIDTH(8), .STAGES(STG_A), .RESET_DATA(8'h00)) u_dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .occupancy (a_occ)
    );

    elastic_pipe #(.WIDTH(32), .STAGES(1), .RESET_DATA(RST_B)) u_dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .occupancy (b_occ)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_t.delete();
        last_out = 8'h00;
    endtask

    // One cycle on instance A: drive, compare to the model, clock, advance the model.
    task automatic step_a(input logic fl, input logic iv, input logic [7:0] din, input logic ordy,
                          output logic s_ir, output logic s_ov, output logic [7:0] s_od,
                          output logic [1:0] s_occ);
        logic       m_ir, m_ov, m_head, push, pop;
        logic [7:0] m_od;
        @(negedge clk);
        a_flush = fl; a_in_valid = iv; a_in_data = din; a_out_ready = ordy;
        #1;
        m_head = (exp_q.size() > 0) && (edge_n - exp_t[0] >= STG_A - 1);
        m_ov   = !fl && m_head;
        m_od   = m_head ? exp_q[0] : last_out;
        m_ir   = !fl && ((exp_q.size() < STG_A) || ordy);
        chk("a_in_ready", 32'(a_in_ready), 32'(m_ir));
        chk("a_out_valid", 32'(a_out_valid), 32'(m_ov));
        chk("a_out_data", 32'(a_out_data), 32'(m_od));
        chk("a_occupancy", 32'(a_occ), 32'(exp_q.size()));
        s_ir = a_in_ready; s_ov = a_out_valid; s_od = a_out_data; s_occ = a_occ;
        push = iv && m_ir;
        pop  = m_ov && ordy;
        @(posedge clk);
        edge_n++;
        if (fl) begin
            model_reset();
        end else begin
            if (pop) begin
                last_out = exp_q.pop_front();
                void'(exp_t.pop_front());
            end
            if (push) begin
                exp_q.push_back(din);
                exp_t.push_back(edge_n);
            end
        end
    endtask

    task automatic step_b(input int idx);
        @(negedge clk);
        b_flush = tab_b[idx].fl; b_in_valid = tab_b[idx].iv;
        b_in_data = tab_b[idx].din; b_out_ready = tab_b[idx].ordy;
        #1;
        chk($sformatf("tab_b[%0d].in_ready", idx), 32'(b_in_ready), 32'(tab_b[idx].e_ir));
        chk($sformatf("tab_b[%0d].out_valid", idx), 32'(b_out_valid), 32'(tab_b[idx].e_ov));
        chk($sformatf("tab_b[%0d].out_data", idx), b_out_data, tab_b[idx].e_od);
        chk($sformatf("tab_b[%0d].occupancy", idx), 32'(b_occ), 32'(tab_b[idx].e_occ));
        @(posedge clk);
    endtask

    initial begin
        logic       s_ir, s_ov;
        logic [7:0] s_od;
        logic [1:0] s_occ;

        //             fl iv din          or  ir ov od           occ
        tab_a[0]  = '{1'b0, 1'b1, 32'h01, 1'b0, 1'b1, 1'b0, 32'h00, 0};
        tab_a[1]  = '{1'b0, 1'b1, 32'h02, 1'b0, 1'b1, 1'b0, 32'h00, 1};
        tab_a[2]  = '{1'b0, 1'b1, 32'h03, 1'b0, 1'b1, 1'b0, 32'h00, 2};
        tab_a[3]  = '{1'b0, 1'b1, 32'h04, 1'b0, 1'b0, 1'b1, 32'h01, 3};
        tab_a[4]  = '{1'b0, 1'b1, 32'h04, 1'b1, 1'b1, 1'b1, 32'h01, 3};
        tab_a[5]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h02, 3};
        tab_a[6]  = '{1'b1, 1'b1, 32'h05, 1'b1, 1'b0, 1'b0, 32'h02, 3};
        tab_a[7]  = '{1'b0, 1'b1, 32'hA1, 1'b1, 1'b1, 1'b0, 32'h00, 0};
        tab_a[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 1};
        tab_a[9]  = '{1'b0, 1'b1, 32'hA2, 1'b1, 1'b1, 1'b0, 32'h00, 1};
        tab_a[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA1, 2};
        tab_a[11] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'hA1, 1};
        tab_a[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA2, 1};
        tab_a[13] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'hA2, 0};

        tab_b[0] = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, RST_B,        0};
        tab_b[1] = '{1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1};
        tab_b[2] = '{1'b0, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1};
        tab_b[3] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 32'h12345678, 1};
        tab_b[4] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 32'h12345678, 1};
        tab_b[5] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'h12345678, 0};
        tab_b[6] = '{1'b1, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h12345678, 0};
        tab_b[7] = '{1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, RST_B,        0};

        reset_n = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a_out_valid", 32'(a_out_valid), 32'h0);
        chk("reset_a_out_data", 32'(a_out_data), 32'h00);
        chk("reset_a_in_ready", 32'(a_in_ready), 32'h1);
        chk("reset_a_occupancy", 32'(a_occ), 32'h0);
        chk("reset_b_out_data", b_out_data, RST_B);
        @(negedge clk);
        reset_n = 1'b1;

        // Depth-1 instance: hold, simultaneous pop/push, flush back to RESET_DATA.
        for (int k = 0; k < 8; k++) step_b(k);

        // Backpressure, full, pop+push when full, flush while full, bubbles.
        for (int k = 0; k < 14; k++) begin
            step_a(tab_a[k].fl, tab_a[k].iv, tab_a[k].din[7:0], tab_a[k].ordy, s_ir, s_ov, s_od, s_occ);
            chk($sformatf("tab_a[%0d].in_ready", k), 32'(s_ir), 32'(tab_a[k].e_ir));
            chk($sformatf("tab_a[%0d].out_valid", k), 32'(s_ov), 32'(tab_a[k].e_ov));
            chk($sformatf("tab_a[%0d].out_data", k), 32'(s_od), tab_a[k].e_od);
            chk($sformatf("tab_a[%0d].occupancy", k), 32'(s_occ), 32'(tab_a[k].e_occ));
        end

        // Reset mid-stream: two words in flight, reset between edges.
        step_a(1'b0, 1'b1, 8'h11, 1'b1, s_ir, s_ov, s_od, s_occ);
        step_a(1'b0, 1'b1, 8'h22, 1'b1, s_ir, s_ov, s_od, s_occ);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(a_out_valid), 32'h0);
        chk("midreset_out_data", 32'(a_out_data), 32'h00);
        chk("midreset_occupancy", 32'(a_occ), 32'h0);
        chk("midreset_in_ready", 32'(a_in_ready), 32'h1);
        model_reset();
        @(negedge clk);
        a_in_valid = 1'b0;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step_a(1'b0, 1'b0, 8'h00, 1'b1, s_ir, s_ov, s_od, s_occ);
            chk("midreset_no_stale", 32'(s_ov), 32'h0);
        end

        // Streaming 0x01..0x10 at full rate.
        for (int k = 1; k <= 16; k++) begin
            step_a(1'b0, 1'b1, 8'(k), 1'b1, s_ir, s_ov, s_od, s_occ);
            if (k >= 4) begin
                chk("stream_occupancy", 32'(s_occ), 32'd3);
                chk("stream_out_valid", 32'(s_ov), 32'h1);
                chk("stream_out_data", 32'(s_od), 32'(k - 3));
            end
        end
        for (int k = 0; k < 4; k++) step_a(1'b0, 1'b0, 8'h00, 1'b1, s_ir, s_ov, s_od, s_occ);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step_a($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
                   $urandom_range(0, 2) != 0, s_ir, s_ov, s_od, s_occ);
        end
        for (int k = 0; k < 6; k++) step_a(1'b0, 1'b0, 8'h00, 1'b1, s_ir, s_ov, s_od, s_occ);
        chk("final_drained", 32'(a_occ), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
